stream_max_reducer: RTL and testbench
=====================================

Name: stream_max_reducer

Overview:
- Streaming max/argmax reduction unit for the softmax front end.
- Accepts a vector as a sequence of LANES-wide beats and returns the maximum element and its flat index.
- Supports signed or unsigned compare per vector, per-lane masking for ragged tails, and valid/ready handshakes on both sides.
- Sits between the score-matrix output buffer and the exp/normalise stage.

Parameters:
- BITWIDTH, 16, element width in bits.
- LANES, 4, elements per input beat; power of two, at least 1.
- IDX_W, 16, width of the flat element index; a vector holds at most 2^IDX_W elements.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  beat valid.
- in_ready  output  1  beat accepted when in_valid && in_ready at a rising edge.
- in_data  input  LANES*BITWIDTH  lane i occupies bits [i*BITWIDTH +: BITWIDTH].
- in_keep  input  LANES  1 = lane participates; 0 = lane ignored.
- in_last  input  1  final beat of the vector.
- in_signed  input  1  two's-complement compare when 1, unsigned when 0. Sampled on the first beat of each vector.
- out_valid  output  1  result valid.
- out_ready  input  1  result consumed when out_valid && out_ready at a rising edge.
- out_max  output  BITWIDTH  maximum kept element.
- out_idx  output  IDX_W  flat index of out_max, computed as beat_number*LANES + lane.
- out_empty  output  1  no lane was kept in the whole vector.

Behaviour:
- Reset, sampled at a clock edge while rst=1:
  - state=S_ACC; all accumulators, stage register and beat counter cleared.
  - out_valid=0, out_max=0, out_idx=0, out_empty=0.
  - in_ready=0 while rst is high.
  - Reset mid-vector or while holding a result discards all partial and held data with no output.
- Stage 1, on each accepted beat:
  - A combinational compare tree over the kept lanes selects the lane max and its lane number.
  - The result is registered together with beat_index, an any_kept flag and the last flag.
- Stage 2, the cycle after stage 1: the registered beat result merges into the running accumulator (acc_max, acc_idx, acc_found).
- Compare rules:
  - Compare is strict greater-than in the vector's sampled mode.
  - Ties keep the lower flat index, both inside a beat (lower lane wins) and across beats (earlier beat wins).
  - Masked lanes never win.
  - A beat with in_keep=0 still advances the beat counter.
- The mode bit is latched on the first beat after S_ACC entry or after a completed vector. in_signed on later beats of the same vector is ignored.
- FSM:
  - S_ACC: in_ready=1. Accepting a beat with in_last=1 moves to S_FLUSH.
  - S_FLUSH: in_ready=0. One cycle for the final stage-2 merge, then move to S_OUT.
  - S_OUT: in_ready=0, out_valid=1. Outputs are held stable until out_ready. On the handshake edge, clear the accumulator and beat counter, set out_valid=0, and return to S_ACC.
- Latency: if the last beat is accepted at edge k, out_valid is high in the cycle after edge k+2. There is no back-to-back overlap between vectors.
- Throughput: one beat per cycle inside a vector.
- Empty vector (no kept lane anywhere): out_empty=1, out_idx=0. out_max is 0 in unsigned mode and the most negative value (1 followed by zeros) in signed mode.
- Index counter: beat_index is IDX_W-log2(LANES) bits wide and wraps silently. Vectors longer than 2^IDX_W elements are out of contract.
- A single-beat vector (in_last on the first beat) follows the same latency.
- Output-side backpressure: out_ready held low keeps S_OUT indefinitely, with all outputs stable.

Test Plan:
- Unsigned, LANES=4, beats {3,9,2,9},{1,9,0,4} with in_last on beat 2 -> out_max=9, out_idx=1, out_empty=0; out_valid rises 2 edges after the last handshake.
- Signed, single beat {0xFFFF,0x8000,0x7FFF,0x0001} -> out_max=0x7FFF, out_idx=2. The same data unsigned -> out_max=0xFFFF, out_idx=0.
- in_keep masking: beat0 keep=0000, beat1 data {5,7,7,1} keep=0110 last -> out_max=7, out_idx=5. All-masked single beat, signed -> out_empty=1, out_max=0x8000, out_idx=0.
- Backpressure: hold out_ready=0 for 10 cycles -> outputs stable and in_ready=0 throughout; an out_ready pulse -> out_valid drops and in_ready=1 the next cycle.
- in_valid toggling every other cycle over a 6-beat vector, plus in_signed flipped mid-vector -> result matches a reference model using the first-beat mode.
- Assert rst for one cycle during beat 3 of 5 -> no out_valid. A following clean vector {4,4,4,4} reports out_idx=0.

Source files
------------

// File: rtl/stream_max_reducer.sv
// Streaming max/argmax reducer: folds LANES-wide beats into one maximum element and its flat
// index, with per-lane masking, per-vector signed/unsigned compare and valid/ready on both sides.
module stream_max_reducer #(
   parameter int unsigned BITWIDTH = 16,
   parameter int unsigned LANES    = 4,
   parameter int unsigned IDX_W    = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LANES*BITWIDTH-1:0] in_data,
   input  logic [LANES-1:0]          in_keep,
   input  logic                      in_last,
   input  logic                      in_signed,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [BITWIDTH-1:0]       out_max,
   output logic [IDX_W-1:0]          out_idx,
   output logic                      out_empty
);

   localparam int unsigned LANE_LG = $clog2(LANES);
   localparam int unsigned LANE_W  = (LANE_LG == 0) ? 1 : LANE_LG;
   localparam int unsigned BEAT_W  = IDX_W - LANE_LG;
   localparam int unsigned NODES   = 2 * LANES - 1;

   typedef enum logic [1:0] {StAcc, StFlush, StOut} state_e;

   state_e               state_q;
   logic                 first_q;
   logic                 mode_q;
   logic [BEAT_W-1:0]    beat_q;

   logic                 s1_valid_q;
   logic [BITWIDTH-1:0]  s1_max_q;
   logic [LANE_W-1:0]    s1_lane_q;
   logic [BEAT_W-1:0]    s1_beat_q;
   logic                 s1_any_q;
   logic                 s1_last_q;

   logic [BITWIDTH-1:0]  acc_max_q;
   logic [IDX_W-1:0]     acc_idx_q;
   logic                 acc_found_q;

   logic                 accept;
   logic                 cur_signed;

   logic [BITWIDTH-1:0]  node_max  [NODES];
   logic [LANE_W-1:0]    node_lane [NODES];
   logic                 node_any  [NODES];

   function automatic logic gt(input logic [BITWIDTH-1:0] a, input logic [BITWIDTH-1:0] b,
                               input logic sgn);
      if (sgn) return $signed(a) > $signed(b);
      else     return a > b;
   endfunction

   assign in_ready   = (state_q == StAcc) && !rst;
   assign accept     = in_valid && in_ready;
   assign cur_signed = first_q ? in_signed : mode_q;

   // Heap-ordered tree: leaves sit at LANES-1.., left child always covers the lower lanes,
   // so taking the right side only on strict greater-than keeps the lowest lane on ties.
   always_comb begin
      for (int i = 0; i < int'(NODES); i++) begin
         node_max[i]  = '0;
         node_lane[i] = '0;
         node_any[i]  = 1'b0;
      end
      for (int i = 0; i < int'(LANES); i++) begin
         node_max[int'(LANES) - 1 + i]  = in_data[i*BITWIDTH +: BITWIDTH];
         node_lane[int'(LANES) - 1 + i] = LANE_W'(i);
         node_any[int'(LANES) - 1 + i]  = in_keep[i];
      end
      for (int n = int'(LANES) - 2; n >= 0; n--) begin
         if (node_any[2*n+2] &&
             (!node_any[2*n+1] || gt(node_max[2*n+2], node_max[2*n+1], cur_signed))) begin
            node_max[n]  = node_max[2*n+2];
            node_lane[n] = node_lane[2*n+2];
         end else begin
            node_max[n]  = node_max[2*n+1];
            node_lane[n] = node_lane[2*n+1];
         end
         node_any[n] = node_any[2*n+1] || node_any[2*n+2];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StAcc;
         first_q     <= 1'b1;
         mode_q      <= 1'b0;
         beat_q      <= '0;
         s1_valid_q  <= 1'b0;
         s1_max_q    <= '0;
         s1_lane_q   <= '0;
         s1_beat_q   <= '0;
         s1_any_q    <= 1'b0;
         s1_last_q   <= 1'b0;
         acc_max_q   <= '0;
         acc_idx_q   <= '0;
         acc_found_q <= 1'b0;
         out_valid   <= 1'b0;
         out_max     <= '0;
         out_idx     <= '0;
         out_empty   <= 1'b0;
      end else begin
         s1_valid_q <= accept;
         s1_last_q  <= accept && in_last;
         if (accept) begin
            s1_max_q  <= node_max[0];
            s1_lane_q <= node_lane[0];
            s1_any_q  <= node_any[0];
            s1_beat_q <= beat_q;
            beat_q    <= beat_q + 1'b1;
            if (first_q) begin
               mode_q  <= in_signed;
               first_q <= 1'b0;
            end
         end

         // Strict compare against the running max keeps the earlier beat on ties.
         if (s1_valid_q && s1_any_q &&
             (!acc_found_q || gt(s1_max_q, acc_max_q, mode_q))) begin
            acc_max_q   <= s1_max_q;
            acc_idx_q   <= (IDX_W'(s1_beat_q) << LANE_LG) | IDX_W'(s1_lane_q);
            acc_found_q <= 1'b1;
         end

         unique case (state_q)
            StAcc: begin
               if (accept && in_last) state_q <= StFlush;
            end
            StFlush: begin
               // s1_last_q drops once the final beat has been merged.
               if (!s1_last_q) begin
                  out_valid <= 1'b1;
                  out_empty <= !acc_found_q;
                  out_idx   <= acc_found_q ? acc_idx_q : '0;
                  if (acc_found_q)  out_max <= acc_max_q;
                  else if (mode_q)  out_max <= {1'b1, {(BITWIDTH-1){1'b0}}};
                  else              out_max <= '0;
                  state_q <= StOut;
               end
            end
            StOut: begin
               if (out_ready) begin
                  out_valid   <= 1'b0;
                  acc_max_q   <= '0;
                  acc_idx_q   <= '0;
                  acc_found_q <= 1'b0;
                  beat_q      <= '0;
                  first_q     <= 1'b1;
                  state_q     <= StAcc;
               end
            end
            default: state_q <= StAcc;
         endcase
      end
   end

endmodule

// File: tb/tb_stream_max_reducer.sv
// Bench for stream_max_reducer: directed vectors with literal results plus randomized vectors
// checked every cycle against a flat-scan reference model.
module tb_stream_max_reducer;

   localparam int BW = 16;
   localparam int LN = 4;
   localparam int IW = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [LN*BW-1:0]  in_data = '0;
   logic [LN-1:0]     in_keep = '0;
   logic              in_last = 1'b0;
   logic              in_signed = 1'b0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [BW-1:0]     out_max;
   logic [IW-1:0]     out_idx;
   logic              out_empty;

   always #5 clk = ~clk;

   stream_max_reducer #(.BITWIDTH(BW), .LANES(LN), .IDX_W(IW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_keep   (in_keep),
      .in_last   (in_last),
      .in_signed (in_signed),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_max   (out_max),
      .out_idx   (out_idx),
      .out_empty (out_empty)
   );

   typedef struct {
      logic [15:0] mx;
      logic [15:0] idx;
      logic        empty;
   } res_t;

   res_t        exp_q[$];
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          acc_edge = 0;
   bit          busy = 1'b0;
   bit          hs_pending = 1'b0;
   int          or_mode = 1;
   bit          m_first = 1'b1;
   bit          m_mode = 1'b0;
   bit          m_found = 1'b0;
   logic [15:0] m_max = '0;
   int          m_beat = 0;
   int          m_idx = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic bit greater(input logic [15:0] a, input logic [15:0] b, input bit sgn);
      if (sgn) return $signed(a) > $signed(b);
      return a > b;
   endfunction

   function automatic logic [63:0] pack(input logic [15:0] a0, input logic [15:0] a1,
                                        input logic [15:0] a2, input logic [15:0] a3);
      return {a3, a2, a1, a0};
   endfunction

   function automatic logic [15:0] rnd_val();
      case ($urandom_range(0, 3))
         0:       return 16'($urandom_range(0, 3));
         1:       return 16'($urandom_range(16'hFFFC, 16'hFFFF));
         2:       return ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h7FFF;
         default: return 16'($urandom);
      endcase
   endfunction

   // Reference: scan elements in flat-index order, strict greater-than in the first beat's mode.
   task automatic model_accept(input logic [63:0] d, input logic [3:0] k, input logic last,
                               input logic sgn);
      if (m_first) begin
         m_mode  = sgn;
         m_first = 1'b0;
      end
      for (int l = 0; l < LN; l++) begin
         logic [15:0] v;
         v = d[l*BW +: BW];
         if (k[l] && (!m_found || greater(v, m_max, m_mode))) begin
            m_found = 1'b1;
            m_max   = v;
            m_idx   = m_beat * LN + l;
         end
      end
      m_beat++;
      if (last) begin
         res_t r;
         r.mx    = m_found ? m_max : (m_mode ? 16'h8000 : 16'h0000);
         r.idx   = m_found ? 16'(m_idx) : 16'h0000;
         r.empty = !m_found;
         exp_q.push_back(r);
         busy     = 1'b1;
         acc_edge = cyc + 1;
         m_first  = 1'b1;
         m_found  = 1'b0;
         m_beat   = 0;
         m_max    = '0;
      end
   endtask

   task automatic send_beat(input logic [63:0] d, input logic [3:0] k, input logic last,
                            input logic sgn);
      int waited;
      waited = 0;
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = d;
      in_keep   = k;
      in_last   = last;
      in_signed = sgn;
      #1;
      while (in_ready !== 1'b1) begin
         if (waited >= 300) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: in_ready=%b after %0d cycles, required 1",
                     in_ready, waited);
            in_valid = 1'b0;
            return;
         end
         @(negedge clk);
         #1;
         waited++;
      end
      model_accept(d, k, last, sgn);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      busy       = 1'b0;
      hs_pending = 1'b0;
      m_first    = 1'b1;
      m_found    = 1'b0;
      m_beat     = 0;
      repeat (n) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic take_result(input string name, input logic [15:0] mx, input logic [15:0] idx,
                              input logic empty, input int hold);
      int t;
      t = 0;
      or_mode = 1;
      while (out_valid !== 1'b1 && t < 50) begin
         @(posedge clk);
         #3;
         t++;
      end
      chk({name, "_valid"}, 32'(out_valid), 32'd1);
      chk({name, "_max"}, 32'(out_max), 32'(mx));
      chk({name, "_idx"}, 32'(out_idx), 32'(idx));
      chk({name, "_empty"}, 32'(out_empty), 32'(empty));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #3;
         chk({name, "_hold_valid"}, 32'(out_valid), 32'd1);
         chk({name, "_hold_max"}, 32'(out_max), 32'(mx));
         chk({name, "_hold_idx"}, 32'(out_idx), 32'(idx));
         chk({name, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      end
      or_mode = 2;
      t = 0;
      while (busy && t < 50) begin
         @(posedge clk);
         #3;
         t++;
      end
      chk({name, "_drained"}, 32'(busy), 32'd0);
      or_mode = 1;
   endtask

   // Output consumer: drives out_ready and notes handshakes for the compare process.
   initial forever begin
      @(negedge clk);
      case (or_mode)
         0:       out_ready = ($urandom_range(0, 1) == 1);
         1:       out_ready = 1'b0;
         default: out_ready = 1'b1;
      endcase
      #1;
      if (out_valid === 1'b1 && out_ready && !rst) hs_pending = 1'b1;
   end

   // Per-cycle compare against the model.
   initial forever begin
      @(posedge clk);
      #2;
      if (hs_pending) begin
         if (exp_q.size() > 0) void'(exp_q.pop_front());
         busy       = 1'b0;
         hs_pending = 1'b0;
      end
      chk("in_ready", 32'(in_ready), 32'(!rst && !busy));
      if (!busy)                    chk("out_valid_idle", 32'(out_valid), 32'd0);
      else if (cyc < acc_edge + 2)  chk("out_valid_early", 32'(out_valid), 32'd0);
      else                          chk("out_valid_due", 32'(out_valid), 32'd1);
      if (out_valid === 1'b1 && exp_q.size() > 0) begin
         chk("model_max", 32'(out_max), 32'(exp_q[0].mx));
         chk("model_idx", 32'(out_idx), 32'(exp_q[0].idx));
         chk("model_empty", 32'(out_empty), 32'(exp_q[0].empty));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required normal completion");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      repeat (3) @(posedge clk);
      #3;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_max", 32'(out_max), 32'd0);
      chk("rst_out_idx", 32'(out_idx), 32'd0);
      chk("rst_out_empty", 32'(out_empty), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      send_beat(pack(16'd3, 16'd9, 16'd2, 16'd9), 4'hF, 1'b0, 1'b0);
      send_beat(pack(16'd1, 16'd9, 16'd0, 16'd4), 4'hF, 1'b1, 1'b0);
      take_result("unsigned_tie", 16'd9, 16'd1, 1'b0, 0);

      send_beat(pack(16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001), 4'hF, 1'b1, 1'b1);
      take_result("signed_bp", 16'h7FFF, 16'd2, 1'b0, 10);
      send_beat(pack(16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001), 4'hF, 1'b1, 1'b0);
      take_result("unsigned_same", 16'hFFFF, 16'd0, 1'b0, 0);

      send_beat(pack(16'd100, 16'd100, 16'd100, 16'd100), 4'h0, 1'b0, 1'b0);
      send_beat(pack(16'd5, 16'd7, 16'd7, 16'd1), 4'b0110, 1'b1, 1'b0);
      take_result("masked", 16'd7, 16'd5, 1'b0, 0);
      send_beat(pack(16'd1, 16'd2, 16'd3, 16'd4), 4'h0, 1'b1, 1'b1);
      take_result("empty_signed", 16'h8000, 16'd0, 1'b1, 2);

      // Gapped 6-beat vector; only the first beat's signed mode counts.
      send_beat(pack(16'h0010, 16'hFFFF, 16'h0003, 16'h8000), 4'hF, 1'b0, 1'b1);
      @(posedge clk);
      send_beat(pack(16'h0020, 16'h0001, 16'hF000, 16'h0002), 4'hF, 1'b0, 1'b0);
      @(posedge clk);
      send_beat(pack(16'h0005, 16'h0030, 16'h0005, 16'h0005), 4'hF, 1'b0, 1'b0);
      @(posedge clk);
      send_beat(pack(16'h9000, 16'h0030, 16'h0001, 16'h0000), 4'hF, 1'b0, 1'b0);
      @(posedge clk);
      send_beat(pack(16'h0000, 16'h0000, 16'h0000, 16'h7000), 4'hF, 1'b0, 1'b1);
      @(posedge clk);
      send_beat(pack(16'hFFFF, 16'h0004, 16'h7000, 16'h0000), 4'hF, 1'b1, 1'b0);
      take_result("mode_first_beat", 16'h7000, 16'd19, 1'b0, 0);

      send_beat(pack(16'd9, 16'd9, 16'd9, 16'd9), 4'hF, 1'b0, 1'b0);
      send_beat(pack(16'd8, 16'd8, 16'd8, 16'd8), 4'hF, 1'b0, 1'b0);
      send_beat(pack(16'd7, 16'd7, 16'd7, 16'd7), 4'hF, 1'b0, 1'b0);
      do_reset(1);
      repeat (6) @(negedge clk);
      send_beat(pack(16'd4, 16'd4, 16'd4, 16'd4), 4'hF, 1'b1, 1'b0);
      take_result("after_reset", 16'd4, 16'd0, 1'b0, 0);

      or_mode = 0;
      for (int v = 0; v < 40; v++) begin
         int nb;
         nb = $urandom_range(1, 8);
         for (int b = 0; b < nb; b++) begin
            logic [63:0] d;
            logic [3:0]  k;
            for (int l = 0; l < LN; l++) d[l*BW +: BW] = rnd_val();
            k = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            send_beat(d, k, b == nb - 1, 1'($urandom));
         end
      end

      t = 0;
      while (busy && t < 300) begin
         @(posedge clk);
         #3;
         t++;
      end
      chk("final_drain", 32'(busy), 32'd0);
      repeat (3) @(posedge clk);
      #3;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
